// File: rtl/pkt_ctl_pkg.sv
// ============================================================================
//  Module   : pkt_ctl_pkg
//  Brief    : Shared widths, decoded-field struct and parity helper for the
//             packet control word path.
//  Revision : 1.0
// ============================================================================
`default_nettype none

// Decoded-field layout, reusable with module-level widths.
`ifndef PKT_CTL_FIELDS_T
`define PKT_CTL_FIELDS_T(AW, FW) struct packed { logic [(AW)-1:0] addr; logic [(FW)-1:0] flags; logic perr; }
`endif

package pkt_ctl_pkg;

    localparam int PKT_PARITY_W = 1;
    localparam int PKT_FLAGS_W  = 12;
    localparam int PKT_ADDR_W   = 20;
    localparam int PKT_MAX_W    = 64;

    typedef `PKT_CTL_FIELDS_T(PKT_ADDR_W, PKT_FLAGS_W) pkt_ctl_fields_t;

    // Even parity over the whole (zero-extended) word.
    function automatic logic pkt_parity_ok(input logic [PKT_MAX_W-1:0] word);
        return ~^word;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pkt_ctl_fifo2.sv
// ============================================================================
//  Module   : pkt_ctl_fifo2
//  Brief    : Generic 2-entry FIFO; full/empty come from registered count only.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module pkt_ctl_fifo2
    import pkt_ctl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == 2'd2);
    assign empty     = (r_count == 2'd0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign pop_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/pkt_ctl_unpack.sv
// ============================================================================
//  Module   : pkt_ctl_unpack
//  Brief    : Unpacks {parity, flags, addr} words, checks even parity, buffers
//             two words and keeps a saturating parity-error counter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module pkt_ctl_unpack
    import pkt_ctl_pkg::*;
#(
    parameter int PARITY   = PKT_PARITY_W,
    parameter int FLAGS    = PKT_FLAGS_W,
    parameter int ADDR     = PKT_ADDR_W,
    parameter bit DROP_BAD = 1'b0,
    parameter int CNT_W    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [PARITY+FLAGS+ADDR-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ADDR-1:0]              out_addr,
    output logic [FLAGS-1:0]             out_flags,
    output logic                         out_perr,
    input  logic                         err_clr,
    output logic [CNT_W-1:0]             err_cnt
);

    localparam int c_w = PARITY + FLAGS + ADDR;

    typedef `PKT_CTL_FIELDS_T(ADDR, FLAGS) fields_t;
    localparam int c_fw = $bits(fields_t);

    if (PARITY != 1) begin : g_parity_check
        $error("pkt_ctl_unpack: PARITY must be 1");
    end

    if (c_w > PKT_MAX_W) begin : g_width_check
        $error("pkt_ctl_unpack: total word width above 64 is not supported");
    end

    logic             w_perr;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    fields_t          w_wr;
    fields_t          w_rd;
    logic [CNT_W-1:0] r_err_cnt;

    assign w_perr    = !pkt_parity_ok(PKT_MAX_W'(in_data));
    assign in_ready  = !rst && !w_full;
    assign w_accept  = in_valid && in_ready;
    assign w_push    = w_accept && !(DROP_BAD && w_perr);
    // Gating with rst keeps out_valid low during the whole reset window.
    assign out_valid = !rst && !w_empty;
    assign w_pop     = out_valid && out_ready;

    always_comb begin
        w_wr       = '0;
        w_wr.addr  = in_data[ADDR-1:0];
        w_wr.flags = in_data[ADDR+FLAGS-1:ADDR];
        w_wr.perr  = w_perr;
    end

    pkt_ctl_fifo2 #(
        .WIDTH (c_fw)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_wr),
        .pop       (w_pop),
        .pop_data  (w_rd),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign out_addr  = w_rd.addr;
    assign out_flags = w_rd.flags;
    assign out_perr  = DROP_BAD ? 1'b0 : w_rd.perr;

    // Clear has priority, so an error accepted in the same cycle is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (err_clr) begin
            r_err_cnt <= '0;
        end else if (w_accept && w_perr && (r_err_cnt != {CNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign err_cnt = r_err_cnt;

endmodule

`default_nettype wire
